// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;
  typedef enum logic {INIT, RUN} arb_state_t;
  localparam int N_PORTS = 2;
endpackage

// File: rtl/sync_one_port_ram.sv
// sync_one_port_ram: single-port RAM with registered read (old data on same-cycle write).
module sync_one_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a
);
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we_a) ram[addr_a] <= din_a;
    dout_a <= ram[addr_a];
  end
endmodule

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin sharing of one RAM between two ports after a zeroing clear pass.
import ram_arb_pkg::*;
module ram_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  init_done
);
  arb_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, addr_q, ram_addr;
  logic [DATA_WIDTH-1:0] ram_din, dout;
  logic [N_PORTS-1:0] rvalid;
  logic last_gnt, ram_we;
  always_comb begin
    state_nx = state;
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    ram_we = 1'b0;
    ram_addr = addr_q;
    ram_din = '0;
    if (state == INIT) begin
      ram_we = 1'b1;
      ram_addr = cnt;
      state_nx = (cnt == '1) ? RUN : INIT;
    end else begin
      gnt_0 = req_0 & (~req_1 | last_gnt);
      gnt_1 = req_1 & ~gnt_0;
      ram_we = gnt_0 ? we_0 : gnt_1 & we_1;
      ram_addr = gnt_0 ? addr_0 : gnt_1 ? addr_1 : addr_q;
      ram_din = gnt_0 ? wdata_0 : wdata_1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      addr_q <= '0;
      last_gnt <= 1'b1;
      rvalid <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state == INIT) ? cnt + ADDR_WIDTH'(1) : cnt;
      addr_q <= ram_addr;
      last_gnt <= gnt_1 ? 1'b1 : gnt_0 ? 1'b0 : last_gnt;
      rvalid <= {gnt_1 & ~we_1, gnt_0 & ~we_0};
      init_done <= (state_nx == RUN);
    end
  end
  sync_one_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk), .we_a(ram_we), .addr_a(ram_addr), .din_a(ram_din), .dout_a(dout)
  );
  assign rvalid_0 = rvalid[0];
  assign rvalid_1 = rvalid[1];
  assign rdata_0 = dout;
  assign rdata_1 = dout;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: randomized scoreboard bench with a spec-level arbiter/RAM model.
module tb_ram_rr_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  typedef struct {int c; logic [DW-1:0] d;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic gnt_0, gnt_1, rvalid_0, rvalid_1, init_done;
  logic [DW-1:0] rdata_0, rdata_1;
  ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .init_done(init_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  bit mon_on = 1'b0;
  exp_t q0[$], q1[$];
  logic [DW-1:0] mem [DEPTH];
  bit mdone = 1'b0, mlast = 1'b1;
  int mcnt = 0;
  logic pr[2], pw[2];
  logic [AW-1:0] pa[2];
  logic [DW-1:0] pd[2];
  logic rst_in = 1'b1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  task automatic req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pr[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
  endtask
  // Reference: grant = lone requester, or on contention the port not granted last.
  task automatic cycle();
    bit eg0, eg1;
    reset = rst_in;
    req_0 = pr[0]; we_0 = pw[0]; addr_0 = pa[0]; wdata_0 = pd[0];
    req_1 = pr[1]; we_1 = pw[1]; addr_1 = pa[1]; wdata_1 = pd[1];
    @(negedge clk);
    eg0 = mdone && pr[0] && (!pr[1] || mlast);
    eg1 = mdone && pr[1] && !eg0;
    chk("gnt_0", gnt_0, eg0);
    chk("gnt_1", gnt_1, eg1);
    chk("init_done", init_done, mdone);
    if (eg0) begin
      mlast = 1'b0;
      if (pw[0]) mem[pa[0]] = pd[0];
      else if (!rst_in) q0.push_back('{cyc, mem[pa[0]]});
    end
    if (eg1) begin
      mlast = 1'b1;
      if (pw[1]) mem[pa[1]] = pd[1];
      else if (!rst_in) q1.push_back('{cyc, mem[pa[1]]});
    end
    if (rst_in) begin
      mdone = 1'b0; mcnt = 0; mlast = 1'b1;
    end else if (!mdone) begin
      mcnt++;
      if (mcnt == DEPTH) begin
        mdone = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      end
    end
    if (gnt_0 === 1'b1) pr[0] = 1'b0;
    if (gnt_1 === 1'b1) pr[1] = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic serve();
    int n = 0;
    while ((pr[0] || pr[1]) && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (pr[0] || pr[1]) begin
      n_bad++;
      $display("FAIL serve_timeout at cycle %0d: pending %0b%0b expected 00", cyc, pr[1], pr[0]);
      pr[0] = 1'b0; pr[1] = 1'b0;
    end
  endtask
  task automatic mon_port(input string n, input logic rv, input logic [DW-1:0] rd, inout exp_t q[$]);
    if (rv === 1'b1) begin
      n_cmp++;
      if (q.size() == 0 || q[0].c != cyc - 1) begin
        n_bad++;
        $display("FAIL %s_unexpected at cycle %0d: rvalid 1 expected 0", n, cyc);
      end else begin
        n_bad += (rd !== q[0].d) ? 1 : 0;
        if (rd !== q[0].d) $display("FAIL %s_rdata at cycle %0d: got %0h expected %0h", n, cyc, rd, q[0].d);
        void'(q.pop_front());
      end
    end else if (q.size() > 0 && q[0].c <= cyc - 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_missing at cycle %0d: rvalid %0b expected 1", n, cyc, rv);
      void'(q.pop_front());
    end
  endtask
  always @(negedge clk) if (mon_on) begin
    mon_port("rvalid_0", rvalid_0, rdata_0, q0);
    mon_port("rvalid_1", rvalid_1, rdata_1, q1);
  end
  initial begin
    for (int p = 0; p < 2; p++) begin
      pr[p] = 1'b0; pw[p] = 1'b0; pa[p] = '0; pd[p] = '0;
    end
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    repeat (2) cycle();
    rst_in = 1'b0;
    // Request held through the clear pass must wait for init_done.
    for (int i = 0; i < DEPTH; i++) begin
      req(0, 1'b0, AW'(i), '0);
      serve();
    end
    req(0, 1'b1, 4'd3, 8'hA5); serve();
    req(0, 1'b0, 4'd3, 8'h00); serve();
    cycle();
    for (int i = 0; i < 16; i++) begin
      if (!pr[0]) req(0, 1'b0, AW'(i), '0);
      if (!pr[1]) req(1, 1'b0, AW'(15 - i), '0);
      cycle();
    end
    serve();
    req(1, 1'b1, 4'd7, 8'h3C); cycle();
    req(0, 1'b0, 4'd7, 8'h00); serve();
    req(1, 1'b0, 4'd1, 8'h00); serve();
    req(0, 1'b0, 4'd5, 8'h00); req(1, 1'b1, 4'd5, 8'hEE); cycle();
    pr[1] = 1'b0; cycle();
    req(1, 1'b0, 4'd5, 8'h00); serve();
    req(0, 1'b1, 4'd2, 8'hFF); serve();
    req(0, 1'b0, 4'd2, 8'h00); cycle();
    rst_in = 1'b1; cycle(); cycle();
    rst_in = 1'b0;
    req(0, 1'b0, 4'd2, 8'h00); serve();
    req(1, 1'b0, 4'd4, 8'h00); rst_in = 1'b1; cycle(); cycle();
    rst_in = 1'b0;
    req(1, 1'b0, 4'd4, 8'h00); serve();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pr[p] && $urandom_range(0, 2) != 0)
          req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        else if (pr[p] && $urandom_range(0, 15) == 0)
          pr[p] = 1'b0;
      end
      cycle();
    end
    pr[0] = 1'b0; pr[1] = 1'b0;
    repeat (3) cycle();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
